// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, source-select encodings and the duty compare helper
// used by the PWM peripheral and its generator sub-module.
package pwm_pkg;

  localparam int NUM_OUT = 8;  // output pins, fixed by the register map
  localparam int DUTY_W  = 8;  // duty and period counter width
  localparam int DIV_W   = 4;  // prescaler divider width per generator
  localparam int SRC_W   = 2;  // per-pin source select width
  localparam int NUM_SRC = 4;  // 2 generators x 2 channels

  typedef enum logic [SRC_W-1:0] {
    SRC_G0C0 = 2'd0,
    SRC_G0C1 = 2'd1,
    SRC_G1C0 = 2'd2,
    SRC_G1C1 = 2'd3
  } src_sel_e;

  // A duty of all-ones means "never low", not "low for one tick".
  localparam logic [DUTY_W-1:0] DUTY_ALWAYS_ON = 8'hFF;

  function automatic logic duty_compare(input logic [DUTY_W-1:0] cnt,
                                        input logic [DUTY_W-1:0] shadow);
    return (shadow == DUTY_ALWAYS_ON) ? 1'b1 : (cnt < shadow);
  endfunction

endpackage

// File: rtl/pwm_generator.sv
// pwm_generator: one prescaler, one 8-bit period counter and two duty
// channels with period-aligned duty shadows.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   div   [3:0]     prescaler divider N; tick period is N+1 clocks
//   duty0 [7:0]     channel 0 duty request (sampled only at the wrap)
//   duty1 [7:0]     channel 1 duty request (sampled only at the wrap)
//   raw   [1:0]     unregistered compare result per channel
module pwm_generator
  import pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  div,
  input  logic [DUTY_W-1:0] duty0,
  input  logic [DUTY_W-1:0] duty1,
  output logic [1:0]        raw
);

  localparam logic [DUTY_W-1:0] CNT_MAX = '1;

  logic [DIV_W-1:0]  pc;
  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] shadow0;
  logic [DUTY_W-1:0] shadow1;
  logic              tick;
  logic              wrap;

  // >= rather than == so that lowering the divider mid-count ticks on the
  // next clock instead of running the 4-bit counter all the way round.
  assign tick = (pc >= div);
  assign wrap = tick && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      cnt     <= '0;
      shadow0 <= '0;
      shadow1 <= '0;
    end else begin
      if (tick) begin
        pc  <= '0;
        cnt <= cnt + 1'b1;
      end else begin
        pc <= pc + 1'b1;
      end
      // Shadows load together with the 255->0 step, so the new duty is
      // in place for cnt==0 and a running pulse is never cut or stretched.
      if (wrap) begin
        shadow0 <= duty0;
        shadow1 <= duty1;
      end
    end
  end

  assign raw[0] = duty_compare(cnt, shadow0);
  assign raw[1] = duty_compare(cnt, shadow1);

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: turns the SPI register file's configuration registers into
// eight registered, glitch-free output pins driven from four PWM sources.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en_out      [7:0]   pin enable; 0 forces the pin low
//   en_pwm_out  [7:0]   pin PWM mode; 0 forces an enabled pin high
//   out_3_0_sel [7:0]   source select for pins 3..0, 2 bits per pin
//   out_7_4_sel [7:0]   source select for pins 7..4, 2 bits per pin
//   g0c0_duty .. g1c1_duty [7:0]  duty per generator/channel
//   freq_div    [7:0]   [3:0] gen0 divider, [7:4] gen1 divider
//   pwm_out     [7:0]   output pins, registered
module pwm_peripheral
  import pwm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_OUT-1:0]  en_out,
  input  logic [NUM_OUT-1:0]  en_pwm_out,
  input  logic [7:0]          out_3_0_sel,
  input  logic [7:0]          out_7_4_sel,
  input  logic [DUTY_W-1:0]   g0c0_duty,
  input  logic [DUTY_W-1:0]   g0c1_duty,
  input  logic [DUTY_W-1:0]   g1c0_duty,
  input  logic [DUTY_W-1:0]   g1c1_duty,
  input  logic [7:0]          freq_div,
  output logic [NUM_OUT-1:0]  pwm_out
);

  logic [1:0]               g0_raw;
  logic [1:0]               g1_raw;
  logic [NUM_SRC-1:0]       src_raw;
  logic [SRC_W*NUM_OUT-1:0] sel_all;
  logic [NUM_OUT-1:0]       pin_next;

  pwm_generator u_gen0 (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (freq_div[DIV_W-1:0]),
    .duty0 (g0c0_duty),
    .duty1 (g0c1_duty),
    .raw   (g0_raw)
  );

  pwm_generator u_gen1 (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (freq_div[2*DIV_W-1:DIV_W]),
    .duty0 (g1c0_duty),
    .duty1 (g1c1_duty),
    .raw   (g1_raw)
  );

  // Bit position in src_raw equals the src_sel_e encoding.
  assign src_raw = {g1_raw[1], g1_raw[0], g0_raw[1], g0_raw[0]};
  assign sel_all = {out_7_4_sel, out_3_0_sel};

  always_comb begin
    pin_next = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (en_out[i]) begin
        pin_next[i] = en_pwm_out[i] ? src_raw[sel_all[SRC_W*i +: SRC_W]] : 1'b1;
      end
    end
  end

  // The only path to the pins is this flop, so the combinational muxing
  // above can never glitch an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pin_next;
    end
  end

endmodule
